// File: rtl/rep_pulse_ctrl_pkg.sv
// rep_pulse_pkg: shared types and default parameters for rep_pulse_ctrl.
// Provides the sequencer state enum and default COUNT/TIMEOUT constants.
package rep_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        LAST  = 2'd2
    } state_t;

    localparam int DEF_COUNT   = 3;
    localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/rep_pulse_ctrl_if.sv
// rep_pulse_ctrl_if: trigger/ready handshake bundle for rep_pulse_ctrl.
// master: sequencer side (drives beat/last/busy/done/err/beat_cnt).
// slave: trigger source + consumer side (drives trig/ready).
interface rep_pulse_ctrl_if #(
    parameter int CNT_W = 2
);
    logic             trig;
    logic             ready;
    logic             beat;
    logic             last;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] beat_cnt;

    modport master (
        input  trig, ready,
        output beat, last, busy, done, err, beat_cnt
    );

    modport slave (
        output trig, ready,
        input  beat, last, busy, done, err, beat_cnt
    );
endinterface

// File: rtl/rep_pulse_ctrl_rise_det.sv
// rise_det: registers the trigger and flags its rising edge.
// Ports: clk, rst_n (async active-low), trig in, rise out (comb).
module rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    output logic rise
);
    logic trig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trig_q <= 1'b0;
        else        trig_q <= trig;
    end

    assign rise = trig & ~trig_q;
endmodule

// File: rtl/rep_pulse_ctrl.sv
// rep_pulse_ctrl: on a trig rise, issues COUNT ready-gated beats then one last/done.
// Ports: clk, rst_n (async active-low), bus (rep_pulse_ctrl_if.master).
// Optional REP_PULSE_CTRL_TIMEOUT_EN: abort with err after TIMEOUT beatless cycles.
module rep_pulse_ctrl
    import rep_pulse_pkg::*;
#(
    parameter int COUNT   = DEF_COUNT,
    parameter int CNT_W   = $clog2(COUNT + 1),
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    rep_pulse_ctrl_if.master  bus
);
    state_t           state, state_n;
    logic             rise;
    logic             beat_c;
    logic             last_c;
    logic             err_c;
    logic [CNT_W-1:0] cnt;
    logic             final_beat;

    rise_det u_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .trig  (bus.trig),
        .rise  (rise)
    );

    assign final_beat = (cnt == CNT_W'(COUNT - 1));

`ifdef REP_PULSE_CTRL_TIMEOUT_EN
    localparam int IDL_W = $clog2(TIMEOUT + 1);
    logic [IDL_W-1:0] idle_cnt;
    logic             idle_hit;

    // Counts consecutive beatless ISSUE cycles; restarts outside ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        idle_cnt <= '0;
        else if (state != ISSUE || beat_c) idle_cnt <= '0;
        else                               idle_cnt <= idle_cnt + 1'b1;
    end

    assign idle_hit = (idle_cnt == IDL_W'(TIMEOUT - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        beat_c  = 1'b0;
        last_c  = 1'b0;
        err_c   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) state_n = ISSUE;
            end
            ISSUE: begin
                beat_c = bus.ready;
                if (beat_c && final_beat) begin
                    state_n = LAST;
                end
`ifdef REP_PULSE_CTRL_TIMEOUT_EN
                else if (!beat_c && idle_hit) begin
                    err_c   = 1'b1;
                    state_n = IDLE;
                end
`endif
            end
            LAST: begin
                last_c  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Cleared only when a burst starts, so the final count stays visible in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    cnt <= '0;
        else if (state == IDLE && rise) cnt <= '0;
        else if (beat_c)               cnt <= cnt + 1'b1;
    end

    assign bus.beat     = beat_c;
    assign bus.last     = last_c;
    assign bus.done     = last_c;
    assign bus.err      = err_c;
    assign bus.busy     = (state != IDLE);
    assign bus.beat_cnt = cnt;
endmodule

// File: tb/tb_rep_pulse_ctrl.sv
// tb_rep_pulse_ctrl: directed self-checking bench for rep_pulse_ctrl.
// COUNT=3, TIMEOUT=4; timeout checks follow REP_PULSE_CTRL_TIMEOUT_EN.
module tb_rep_pulse_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    rep_pulse_ctrl_if #(.CNT_W(2)) bus ();

    rep_pulse_ctrl #(
        .COUNT   (3),
        .TIMEOUT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input int obs, input int expv);
        n_chk++;
        if (obs == expv) n_pass++;
        else $display("FAIL %s: got %0d want %0d", tag, obs, expv);
    endtask

    // Flags packed as {beat,last,busy,done,err}; done must equal last.
    task automatic exp(input string tag, input logic b, input logic l,
                       input logic bz, input logic e, input int c);
        logic [4:0] want;
        logic [4:0] got;
        want = {b, l, bz, l, e};
        got  = {bus.beat, bus.last, bus.busy, bus.done, bus.err};
        chk({tag, ".flags"}, int'(got), int'(want));
        chk({tag, ".cnt"}, int'(bus.beat_cnt), c);
    endtask

    task automatic step(input logic t, input logic r);
        @(posedge clk);
        #1;
        bus.trig  = t;
        bus.ready = r;
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.trig  = 1'b0;
        bus.ready = 1'b0;
        repeat (2) @(negedge clk);
        exp("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // basic burst, trig held high past completion
        step(0, 1); exp("t1.idle", 0, 0, 0, 0, 0);
        step(1, 1); exp("t1.rise", 0, 0, 0, 0, 0);
        step(1, 1); exp("t1.b0", 1, 0, 1, 0, 0);
        step(1, 1); exp("t1.b1", 1, 0, 1, 0, 1);
        step(1, 1); exp("t1.b2", 1, 0, 1, 0, 2);
        step(1, 1); exp("t1.last", 0, 1, 1, 0, 3);
        step(1, 1); exp("t1.held0", 0, 0, 0, 0, 3);
        step(1, 1); exp("t1.held1", 0, 0, 0, 0, 3);

        // ready pattern 1,0,0,1,0,1
        step(0, 0); exp("t2.idle", 0, 0, 0, 0, 3);
        step(1, 0); exp("t2.rise", 0, 0, 0, 0, 3);
        step(1, 1); exp("t2.c3", 1, 0, 1, 0, 0);
        step(1, 0); exp("t2.c4", 0, 0, 1, 0, 1);
        step(1, 0); exp("t2.c5", 0, 0, 1, 0, 1);
        step(1, 1); exp("t2.c6", 1, 0, 1, 0, 1);
        step(1, 0); exp("t2.c7", 0, 0, 1, 0, 2);
        step(1, 1); exp("t2.c8", 1, 0, 1, 0, 2);
        step(1, 0); exp("t2.last", 0, 1, 1, 0, 3);
        step(0, 0); exp("t2.after", 0, 0, 0, 0, 3);

        // rises during ISSUE and on the LAST cycle are ignored
        step(1, 1); exp("t3.rise", 0, 0, 0, 0, 3);
        step(0, 1); exp("t3.b0", 1, 0, 1, 0, 0);
        step(1, 1); exp("t3.b1", 1, 0, 1, 0, 1);
        step(0, 1); exp("t3.b2", 1, 0, 1, 0, 2);
        step(1, 1); exp("t3.last", 0, 1, 1, 0, 3);
        step(1, 1); exp("t3.idle0", 0, 0, 0, 0, 3);
        step(1, 1); exp("t3.idle1", 0, 0, 0, 0, 3);
        step(0, 1); exp("t3.idle2", 0, 0, 0, 0, 3);
        step(1, 1); exp("t3.rise2", 0, 0, 0, 0, 3);
        step(1, 1); exp("t3.n0", 1, 0, 1, 0, 0);
        step(1, 1); exp("t3.n1", 1, 0, 1, 0, 1);
        step(1, 1); exp("t3.n2", 1, 0, 1, 0, 2);
        step(0, 1); exp("t3.nlast", 0, 1, 1, 0, 3);

        // ready drops after the first beat
        step(0, 0); exp("t4.idle", 0, 0, 0, 0, 3);
        step(1, 1); exp("t4.rise", 0, 0, 0, 0, 3);
        step(1, 1); exp("t4.b0", 1, 0, 1, 0, 0);
`ifdef REP_PULSE_CTRL_TIMEOUT_EN
        step(1, 0); exp("t4.w1", 0, 0, 1, 0, 1);
        step(1, 0); exp("t4.w2", 0, 0, 1, 0, 1);
        step(1, 0); exp("t4.w3", 0, 0, 1, 0, 1);
        step(1, 0); exp("t4.err", 0, 0, 1, 1, 1);
        step(1, 0); exp("t4.idle2", 0, 0, 0, 0, 1);
        step(0, 1); exp("t4.idle3", 0, 0, 0, 0, 1);
`else
        for (int i = 0; i < 8; i++) begin
            step(1, 0); exp("t4.wait", 0, 0, 1, 0, 1);
        end
        step(1, 1); exp("t4.b1", 1, 0, 1, 0, 1);
        step(0, 1); exp("t4.b2", 1, 0, 1, 0, 2);
        step(0, 1); exp("t4.last", 0, 1, 1, 0, 3);
        step(0, 1); exp("t4.idle2", 0, 0, 0, 0, 3);
`endif

        // async reset mid-burst, then a full fresh burst
        step(1, 1); exp("t5.rise", 0, 0, 0, 0, -1 + 1 + int'(bus.beat_cnt));
        step(0, 1); exp("t5.b0", 1, 0, 1, 0, 0);
        step(0, 1); exp("t5.b1", 1, 0, 1, 0, 1);
        #2 rst_n = 1'b0;
        #1 exp("t5.rst", 0, 0, 0, 0, 0);
        step(0, 1); exp("t5.rsthold", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step(0, 1); exp("t5.idle", 0, 0, 0, 0, 0);
        step(1, 1); exp("t5.rise2", 0, 0, 0, 0, 0);
        step(1, 1); exp("t5.n0", 1, 0, 1, 0, 0);
        step(1, 1); exp("t5.n1", 1, 0, 1, 0, 1);
        step(1, 1); exp("t5.n2", 1, 0, 1, 0, 2);
        step(1, 1); exp("t5.last", 0, 1, 1, 0, 3);
        step(1, 1); exp("t5.done", 0, 0, 0, 0, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
